// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types, ALU opcodes and the EX/MEM bundle.
package cpu_pkg;
    localparam int XLEN = 64;
    localparam int REG_IDX_W = 5;
    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_HS, COND_LO, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;
    typedef enum logic [1:0] {BR_NONE, BR_UNCOND, BR_COND, BR_CBZ} br_kind_e;
    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;
    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [XLEN-1:0]      store_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } exmem_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: ARM condition-code evaluation against {N,Z,C,V}.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;
    always_comb begin
        case (cond_e'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c & !z;
            COND_LS: taken = !c | z;
            COND_GE: taken = n == v;
            COND_LT: taken = n != v;
            COND_GT: taken = !z & (n == v);
            COND_LE: taken = z | (n != v);
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/exmem_flag_stage.sv
// exmem_flag_stage: EX/MEM register with NZCV ownership and branch resolution.
module exmem_flag_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int REG_W  = REG_IDX_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry_out,
    input  logic              set_flags,
    input  logic [1:0]        br_kind,
    input  logic [3:0]        cond,
    input  logic [DATA_W-1:0] br_target,
    input  logic [REG_W-1:0]  rd,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] store_data,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_result,
    output logic [DATA_W-1:0] m_store_data,
    output logic [REG_W-1:0]  m_rd,
    output logic              m_reg_write,
    output logic              m_mem_read,
    output logic              m_mem_write,
    output logic [3:0]        flags,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc
);
    exmem_t   bundle;
    br_kind_e br;
    logic     fire, is_br, cond_taken, taken;
    assign br       = br_kind_e'(br_kind);
    assign ex_ready = !m_valid | mem_ready;
    assign fire     = ex_valid & ex_ready & !flush;
    assign is_br    = br != BR_NONE;
    // B.cond sees the flag register before this cycle's update
    cond_eval u_cond_eval (.flags(flags), .cond(cond), .taken(cond_taken));
    assign taken = (br == BR_UNCOND) | ((br == BR_COND) & cond_taken) | ((br == BR_CBZ) & alu_zero);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid     <= 1'b0;
            bundle      <= '0;
            flags       <= 4'b0000;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= fire & taken;
            if (fire & taken) redirect_pc <= br_target;
            if (fire) begin
                m_valid <= 1'b1;
                bundle  <= '{result: alu_result, store_data: store_data, rd: rd,
                             reg_write: reg_write & !is_br, mem_read: mem_read & !is_br,
                             mem_write: mem_write & !is_br};
                if (set_flags) flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
            end else if (mem_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
    assign m_result     = bundle.result;
    assign m_store_data = bundle.store_data;
    assign m_rd         = bundle.rd;
    assign m_reg_write  = bundle.reg_write;
    assign m_mem_read   = bundle.mem_read;
    assign m_mem_write  = bundle.mem_write;
endmodule

// File: doc/exmem_flag_stage.md
# exmem_flag_stage

Execute-to-memory pipeline stage that sits directly downstream of the 64-bit ALU. It captures the ALU result and flags together with the instruction's control bundle into the EX/MEM register. It owns the architectural NZCV flag register and resolves conditional, CBZ and unconditional branches. It applies valid/ready backpressure toward ID/EX and honours a flush from hazard control.

## Interface
Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register-index width

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_ready  out  1  stage can accept the EX instruction this cycle
- alu_result  in  DATA_W  ALU result
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags
- set_flags  in  1  instruction writes NZCV (ADDS/SUBS)
- br_kind  in  2  0 none, 1 unconditional, 2 B.cond, 3 CBZ
- cond  in  4  ARM condition code for B.cond
- br_target  in  DATA_W  precomputed branch target
- rd, reg_write, mem_read, mem_write  in  REG_W/1/1/1  control pass-through
- store_data  in  DATA_W  store operand pass-through
- flush  in  1  kill the instruction currently in EX
- mem_ready  in  1  MEM stage accepts this cycle
- m_valid  out  1  EX/MEM register holds a valid instruction
- m_result, m_store_data, m_rd, m_reg_write, m_mem_read, m_mem_write  out  registered bundle
- flags  out  4  architectural {N,Z,C,V}
- redirect  out  1  one-cycle pulse, taken branch
- redirect_pc  out  DATA_W  target accompanying redirect

## Operation
- Accept: fire = ex_valid & ex_ready & !flush. ex_ready = !m_valid | mem_ready.
- On fire, the EX/MEM register loads the bundle and sets m_valid=1. If MEM drains with no fire, m_valid drops to 0. If !ex_ready, the register and flags hold.
- Flag register: on fire & set_flags, flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}. No update otherwise, including for flushed or stalled instructions.
- Branch resolution, evaluated on fire:
  - Unconditional: taken.
  - CBZ: taken = alu_zero. The ALU runs PASS_B on the tested register.
  - B.cond: taken = cond_eval(flags, cond), using the flag register value before any update this cycle.
  - Conditions: EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V). AL and NV are always taken.
- A taken branch sets redirect=1 and redirect_pc=br_target on the next cycle, for exactly one cycle.
- Branch instructions force m_reg_write=0, m_mem_read=0 and m_mem_write=0.

## Timing
- Reset (async assert, sync-safe deassert): m_valid=0, flags=4'b0000, redirect=0, redirect_pc=0, m_result=0, m_store_data=0, m_rd=0, all m_ control bits=0.
- Latency: 1 cycle from fire to m_valid/bundle and to redirect.
- ex_ready is combinational from m_valid and mem_ready only. It is never a function of ex_valid.
- flush & stall in the same cycle: flush kills only the EX instruction. The held EX/MEM contents are untouched.
- flush & mem_ready in the same cycle: the register drains, so m_valid=0 next cycle.
- Back-to-back ADDS then B.cond: the B.cond fires a cycle later and sees the updated flags, with no bubble.
- A set_flags instruction that is also a branch is illegal. It is not handled specially.
- Reset mid-stall discards the held instruction and any pending redirect.

## Structure
- Shared package `cpu_pkg`:
  - `cond_e` enum with the 16 condition codes.
  - `br_kind_e` enum.
  - ALU control constants (PASS_B 000, ADD 010, SUBTRACT 011, AND 100, OR 101, XOR 110).
  - `exmem_t` struct for the registered bundle.
- One combinational sub-module, `cond_eval` (flags[3:0], cond[3:0] -> taken), reused by any later decode-stage predictor.

## Test plan
- Reset release, then ADDS with alu_result=0, zero=1, carry_out=1, set_flags=1, mem_ready=1 -> next cycle m_valid=1, m_result=0, flags=4'b0110.
- SUBS 2-3 (negative=1, carry_out=0), then B.cond LT with br_target=64'h40 -> redirect pulses once with redirect_pc=64'h40. B.cond GE under the same flags -> no redirect.
- CBZ with alu_zero=0 -> no redirect, m_reg_write=0. CBZ with alu_zero=1 -> redirect=1 for one cycle.
- mem_ready=0 with m_valid=1 and ex_valid=1 -> ex_ready=0. Bundle and flags are unchanged across 3 stall cycles, and the instruction is accepted the cycle mem_ready rises.
- flush with a SUBS in EX (set_flags=1) -> m_valid=0 and flags unchanged. Flush while stalled -> the held m_result is preserved.
- Assert reset_n=0 mid-stall with flags=4'b1001 -> immediately m_valid=0, flags=0, redirect=0.
